led_counter_ctrl: RTL and testbench

//  Run/pause/direction controller for the Basys-3 LED up/down counter datapath.

---
 rtl/led_ctrl_pkg.sv | 29 ++
 rtl/led_counter_ctrl_btn_debounce.sv | 52 +++++
 rtl/led_counter_ctrl.sv | 154 +++++++++++++++
 tb/tb_led_counter_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED counter run/pause/direction controller.
package led_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ENC_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ENC_RUN_UP = 3'd1;
    localparam logic [STATE_W-1:0] ENC_RUN_DN = 3'd2;
    localparam logic [STATE_W-1:0] ENC_BNC_UP = 3'd3;
    localparam logic [STATE_W-1:0] ENC_BNC_DN = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = ENC_IDLE,
        S_RUN_UP = ENC_RUN_UP,
        S_RUN_DN = ENC_RUN_DN,
        S_BNC_UP = ENC_BNC_UP,
        S_BNC_DN = ENC_BNC_DN
    } ctrl_state_t;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_counter_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability filter, registered rise pulse.
module btn_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int            CW       = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_level_d;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // Level only follows the synced input after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_s1      <= i_btn;
            r_s2      <= r_s1;
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/led_counter_ctrl.sv
// Run/pause/direction FSM, prescaler and strobe outputs for the LED up/down counter.
// Define LED_CTRL_BOUNCE_EN to enable the bounce (ping-pong) count mode.
module led_counter_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 5,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int WIDTH      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_run,
    input  logic               btn_dir,
    input  logic               btn_mode,
    input  logic               btn_clr,
    input  logic [WIDTH-1:0]   cnt_val,
    output logic               cnt_en,
    output logic               cnt_dir,
    output logic               cnt_clr,
    output logic               running,
    output logic [STATE_W-1:0] state_o
);

    localparam int               DIV      = calc_div(CLK_HZ, TICK_HZ);
    localparam int               PW       = cnt_w(DIV);
    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] VAL_MAX  = '1;

    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // Assert asynchronously, release two clocks later so all flops leave reset together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic w_run_lvl, w_dir_lvl, w_mode_lvl, w_clr_lvl;
    logic w_run_ev, w_dir_ev, w_mode_ev, w_clr_ev;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_btn(btn_run),  .o_level(w_run_lvl),  .o_rise(w_run_ev));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_btn(btn_dir),  .o_level(w_dir_lvl),  .o_rise(w_dir_ev));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_btn(btn_mode), .o_level(w_mode_lvl), .o_rise(w_mode_ev));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_btn(btn_clr),  .o_level(w_clr_lvl),  .o_rise(w_clr_ev));

    logic w_unused;
    assign w_unused = ^{w_run_lvl, w_dir_lvl, w_mode_lvl, w_clr_lvl, w_mode_ev, cnt_val};

    ctrl_state_t   r_state, w_state_nxt;
    logic          r_dir, w_dir_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic          r_cnt_en, r_cnt_dir, r_cnt_clr, r_running;
    logic [STATE_W-1:0] r_state_o;
    logic          w_en_nxt, w_cnt_dir_nxt, w_clr_nxt;
    logic          w_run_st, w_up_st, w_tc;

    assign w_run_st = (r_state != S_IDLE);
    assign w_up_st  = (r_state == S_RUN_UP) || (r_state == S_BNC_UP);
    assign w_tc     = w_run_st && (r_presc == PRE_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_dir_nxt     = r_dir;
        w_presc_nxt   = '0;
        w_en_nxt      = 1'b0;
        w_cnt_dir_nxt = r_cnt_dir;
        w_clr_nxt     = 1'b0;

        if (w_run_st) w_presc_nxt = (r_presc == PRE_LAST) ? '0 : r_presc + 1'b1;

        // A step that is due is always issued, using the direction of the state it was due in.
        if (w_tc) begin
            w_en_nxt      = 1'b1;
            w_cnt_dir_nxt = w_up_st;
`ifdef LED_CTRL_BOUNCE_EN
            if (r_state == S_BNC_UP && cnt_val == VAL_MAX) begin
                w_cnt_dir_nxt = 1'b0;
                w_state_nxt   = S_BNC_DN;
            end else if (r_state == S_BNC_DN && cnt_val == '0) begin
                w_cnt_dir_nxt = 1'b1;
                w_state_nxt   = S_BNC_UP;
            end
`endif
        end

        if (w_clr_ev) begin
            w_clr_nxt   = 1'b1;
            w_presc_nxt = '0;
        end else if (w_run_ev) begin
            w_presc_nxt = '0;
            if (r_state == S_IDLE) begin
                w_state_nxt = r_dir ? S_RUN_UP : S_RUN_DN;
            end else begin
                w_state_nxt = S_IDLE;
                w_dir_nxt   = w_up_st;
            end
        end else if (w_dir_ev) begin
            case (r_state)
                S_IDLE:   w_dir_nxt   = ~r_dir;
                S_RUN_UP: w_state_nxt = S_RUN_DN;
                S_RUN_DN: w_state_nxt = S_RUN_UP;
                S_BNC_UP: w_state_nxt = S_BNC_DN;
                S_BNC_DN: w_state_nxt = S_BNC_UP;
                default:  w_state_nxt = r_state;
            endcase
        end
`ifdef LED_CTRL_BOUNCE_EN
        else if (w_mode_ev) begin
            case (r_state)
                S_RUN_UP: w_state_nxt = S_BNC_UP;
                S_BNC_UP: w_state_nxt = S_RUN_UP;
                S_RUN_DN: w_state_nxt = S_BNC_DN;
                S_BNC_DN: w_state_nxt = S_RUN_DN;
                default:  w_state_nxt = r_state;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b1;
            r_presc   <= '0;
            r_cnt_en  <= 1'b0;
            r_cnt_dir <= 1'b1;
            r_cnt_clr <= 1'b0;
            r_running <= 1'b0;
            r_state_o <= ENC_IDLE;
        end else begin
            r_state   <= w_state_nxt;
            r_dir     <= w_dir_nxt;
            r_presc   <= w_presc_nxt;
            r_cnt_en  <= w_en_nxt;
            r_cnt_dir <= w_cnt_dir_nxt;
            r_cnt_clr <= w_clr_nxt;
            r_running <= (w_state_nxt != S_IDLE);
            r_state_o <= w_state_nxt;
        end
    end

    assign cnt_en  = r_cnt_en;
    assign cnt_dir = r_cnt_dir;
    assign cnt_clr = r_cnt_clr;
    assign running = r_running;
    assign state_o = r_state_o;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Self-checking bench for led_counter_ctrl: directed scenarios plus random button traffic
// checked every cycle against a behavioural model of the controller and counter datapath.
module tb_led_counter_ctrl;

    localparam int DIV    = 10;
    localparam int DEB    = 4;
    localparam int EV_LAT = DEB + 4;   // drive cycle -> edge at which the FSM acts
    localparam bit [3:0] B_CLR = 4'b0001, B_RUN = 4'b0010, B_DIR = 4'b0100, B_MODE = 4'b1000;
`ifdef LED_CTRL_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_run = 1'b0, btn_dir = 1'b0, btn_mode = 1'b0, btn_clr = 1'b0;
    logic [7:0] cnt_val = 8'd0;
    logic       cnt_en, cnt_dir, cnt_clr, running;
    logic [2:0] state_o;

    led_counter_ctrl #(.CLK_HZ(100), .TICK_HZ(10), .DEB_CYCLES(DEB), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_dir(btn_dir),
        .btn_mode(btn_mode), .btn_clr(btn_clr), .cnt_val(cnt_val),
        .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_clr(cnt_clr),
        .running(running), .state_o(state_o));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_seen  = 0;
    int clr_seen = 0;

    // Reference model: state numbered as in the spec (0 idle, 1/2 run up/down, 3/4 bounce up/down)
    int       m_state, m_phase, m_cnt = 0;
    bit       m_dir, m_en, m_edir, m_clr;
    bit [3:0] ev_sched [int];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_dir = 1'b1; m_phase = 0;
        m_en = 1'b0; m_edir = 1'b1; m_clr = 1'b0;
        ev_sched.delete();
    endtask

    task automatic model_step();
        bit [3:0] ev;
        bit       up, tc;
        int       nxt, cnt_pre;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cnt_pre = m_cnt;
        if (m_clr)     m_cnt = 0;
        else if (m_en) m_cnt = m_edir ? (m_cnt + 1) % 256 : (m_cnt + 255) % 256;
        ev = 4'b0;
        if (ev_sched.exists(cyc)) begin
            ev = ev_sched[cyc];
            ev_sched.delete(cyc);
        end
        up  = (m_state == 1) || (m_state == 3);
        tc  = (m_state != 0) && (m_phase == DIV - 1);
        nxt = m_state;
        m_en  = tc;
        m_clr = 1'b0;
        if (tc) begin
            m_edir = up;
            if (BOUNCE && m_state == 3 && cnt_pre == 255) begin m_edir = 1'b0; nxt = 4; end
            else if (BOUNCE && m_state == 4 && cnt_pre == 0) begin m_edir = 1'b1; nxt = 3; end
        end
        m_phase = (m_state != 0) ? (m_phase + 1) % DIV : 0;
        if (ev[0]) begin
            m_clr = 1'b1; m_phase = 0;
        end else if (ev[1]) begin
            m_phase = 0;
            if (m_state == 0) nxt = m_dir ? 1 : 2;
            else begin nxt = 0; m_dir = up; end
        end else if (ev[2]) begin
            if (m_state == 0) m_dir = !m_dir;
            else nxt = (m_state == 1) ? 2 : (m_state == 2) ? 1 : (m_state == 3) ? 4 : 3;
        end else if (ev[3] && BOUNCE && m_state != 0) begin
            nxt = (m_state == 1) ? 3 : (m_state == 3) ? 1 : (m_state == 2) ? 4 : 2;
        end
        m_state = nxt;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            #1 cnt_val = 8'(m_cnt);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check_eq("cnt_en",  cnt_en,  m_en);
            check_eq("cnt_clr", cnt_clr, m_clr);
            check_eq("running", running, m_state != 0);
            check_eq("state_o", state_o, m_state);
            if (m_en) check_eq("cnt_dir", cnt_dir, m_edir);
            en_seen  += int'(cnt_en);
            clr_seen += int'(cnt_clr);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit [3:0] mask, input int len, input int gap);
        int k;
        k = cyc + EV_LAT;
        if (len >= DEB) ev_sched[k] = (ev_sched.exists(k) ? ev_sched[k] : 4'b0) | mask;
        btn_clr = mask[0]; btn_run = mask[1]; btn_dir = mask[2]; btn_mode = mask[3];
        tick(len);
        btn_clr = 1'b0; btn_run = 1'b0; btn_dir = 1'b0; btn_mode = 1'b0;
        tick(gap);
    endtask

    task automatic set_cnt(input int v);
        m_cnt   = v;
        cnt_val = 8'(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"},    cnt_en,  0);
        check_eq({tag, "_dir"},   cnt_dir, 1);
        check_eq({tag, "_clr"},   cnt_clr, 0);
        check_eq({tag, "_run"},   running, 0);
        check_eq({tag, "_state"}, state_o, 0);
    endtask

    initial begin
        int c0, e0, k0, b;
        bit [3:0] mask;
        int len;

        tick(4);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(6);

        press(B_RUN, 2, 12);
        check_eq("glitch_state", state_o, 0);
        check_eq("glitch_no_step", en_seen, 0);

        c0 = cyc;
        press(B_RUN, 10, 0);
        b = 0;
        while (!cnt_en && b < 40) begin tick(1); b++; end
        check_eq("first_step_lat", cyc - c0, DEB + 3 + DIV + 1);
        check_eq("run_up_state", state_o, 1);
        check_eq("run_up_dir", cnt_dir, 1);
        check_eq("run_up_running", running, 1);
        c0 = cyc;
        tick(1);
        b = 0;
        while (!cnt_en && b < 30) begin tick(1); b++; end
        check_eq("step_period", cyc - c0, DIV);

        tick(3);
        press(B_DIR, 8, 10);
        check_eq("dir_to_dn", state_o, 2);
        b = 0;
        while (!cnt_en && b < 30) begin tick(1); b++; end
        check_eq("dn_strobe_dir", cnt_dir, 0);

        press(B_RUN, 8, 10);
        check_eq("pause_state", state_o, 0);
        e0 = en_seen;
        tick(25);
        check_eq("idle_no_step", en_seen - e0, 0);
        press(B_RUN, 8, 10);
        check_eq("resume_dn", state_o, 2);

        press(B_RUN, 8, 10);
        k0 = clr_seen;
        press(B_CLR | B_RUN, 8, 12);
        check_eq("clr_run_pulses", clr_seen - k0, 1);
        check_eq("clr_run_state", state_o, 0);

        press(B_RUN, 8, 10);
        check_eq("rerun_dn", state_o, 2);
        b = 0;
        while (!cnt_en && b < 30) begin tick(1); b++; end
        tick(3);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("midrun_rst");
        tick(3);
        rst_n = 1'b1;
        e0 = en_seen;
        tick(40);
        check_eq("post_rst_no_step", en_seen - e0, 0);
        check_eq("post_rst_state", state_o, 0);
        press(B_RUN, 8, 10);
        check_eq("post_rst_run_up", state_o, 1);
        press(B_RUN, 8, 10);

`ifdef LED_CTRL_BOUNCE_EN
        press(B_RUN, 8, 10);
        press(B_MODE, 8, 10);
        check_eq("bnc_up_state", state_o, 3);
        set_cnt(250);
        b = 0;
        while (state_o != 3'd4 && b < 150) begin tick(1); b++; end
        check_eq("bnc_turn_dn", state_o, 4);
        check_eq("bnc_turn_dn_en", cnt_en, 1);
        check_eq("bnc_turn_dn_dir", cnt_dir, 0);
        set_cnt(3);
        b = 0;
        while (state_o != 3'd3 && b < 150) begin tick(1); b++; end
        check_eq("bnc_turn_up", state_o, 3);
        check_eq("bnc_turn_up_en", cnt_en, 1);
        check_eq("bnc_turn_up_dir", cnt_dir, 1);
        press(B_RUN, 8, 10);
        press(B_MODE, 8, 10);
        check_eq("mode_idle_ignored", state_o, 0);
`else
        press(B_RUN, 8, 10);
        press(B_MODE, 8, 10);
        check_eq("mode_unused", state_o, 1);
        press(B_RUN, 8, 10);
`endif

        repeat (40) begin
            case ($urandom_range(0, 9))
                0, 1, 2: mask = B_RUN;
                3, 4:    mask = B_DIR;
                5, 6:    mask = B_MODE;
                7:       mask = B_CLR;
                8:       mask = B_CLR | B_RUN;
                default: mask = ($urandom_range(0, 1) == 0) ? B_RUN : B_DIR;
            endcase
            len = (mask == B_RUN || mask == B_DIR) && ($urandom_range(0, 4) == 0)
                  ? $urandom_range(1, 2) : $urandom_range(DEB + 1, DEB + 5);
            press(mask, len, $urandom_range(DEB + 4, 35));
        end
        tick(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
